axi_burst_master: RTL
=====================

Name: axi_burst_master

Overview:
- Parametrised AXI4 master bridge that supersedes the single-beat master behind the CPU memory ports.
- Accepts one request at a time from a core-side port: INCR bursts of 1..2^LEN_W beats for both read and write.
- Per-beat data streams out for reads; write data is pulled per beat from the requester.
- Reports completion with an error flag; it is intended for cache-line fills and DMA-style transfers in the CPU wrapper.

Parameters:
ID_W, 4, AXI ID width
ID_VAL, 0, constant ID driven on ARID/AWID
ADDR_W, 32, address width
DATA_W, 32, data width; STRB_W = DATA_W/8
LEN_W, 4, AXI LEN width; burst length = len+1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_write  in  1  1 write, 0 read
req_addr  in  ADDR_W  start address, word aligned
req_len  in  LEN_W  beats-1
wr_data  in  DATA_W  current write beat
wr_strb  in  STRB_W  current write strobe
wr_pop  out  1  pulse: current write beat consumed, present next beat
rd_data  out  DATA_W  read beat data
rd_valid  out  1  one pulse per read beat
rd_last  out  1  with rd_valid on final beat
done  out  1  one-cycle completion pulse
err  out  1  valid with done; 1 = any non-OKAY response or LEN mismatch
AXI AR/R/AW/W/B master channels  AR*, R*, AW*, W*, B*  standard AXI4 widths per parameters

Behaviour:
- Reset (synchronous): state IDLE; all *VALID, RREADY, BREADY, rd_valid, wr_pop, done, err = 0; registered address/len/ID outputs = 0. A reset mid-burst abandons the transaction with no drain; the interconnect is reset together with this block.
- Fixed fields: ARSIZE/AWSIZE = log2(STRB_W), ARBURST/AWBURST = INCR (2'b01), IDs = ID_VAL.
- States: IDLE, AR, R, AW, W, B.
- IDLE -> AR or AW on req_valid&&req_ready (cycle N). Addr/len are latched; *VALID rises at N+1. The beat counter and error accumulator are cleared.
- AR: ARVALID held with stable ARADDR/ARLEN until ARREADY; then R.
- R:
  - RREADY = 1 throughout.
  - On each RVALID: rd_data = RDATA and rd_valid pulse next cycle (1-cycle registered latency); counter increments.
  - Any RRESP != OKAY sets err.
  - On RLAST: err is also set if counter != len; go to IDLE.
  - If counter reaches len without RLAST, further beats are accepted until RLAST and err is set.
- AW: AWVALID held until AWREADY; then W. AW completes before W is driven; no overlap.
- W:
  - WVALID = 1; WDATA/WSTRB driven combinationally from wr_data/wr_strb; WLAST = (counter == len).
  - On WVALID&&WREADY: wr_pop pulses the same cycle and the counter increments.
  - Last beat -> B. WVALID drops the cycle after the final handshake.
- B: BREADY = 1; on BVALID, err |= (BRESP != OKAY) and BID != ID_VAL also sets err; go to IDLE.
- done: a one-cycle pulse in the first IDLE cycle after a completed transaction; err is valid in that cycle and holds until the next accepted request.
- req_ready is combinational (state == IDLE), so back-to-back requests are possible in the done cycle.
- RID mismatch sets err but data is still forwarded.
- Counter is LEN_W bits and never wraps: len max gives 2^LEN_W beats, and the final increment is suppressed.
- Address not incremented internally; the slave handles INCR.

Decomposition:
- Package axi_master_pkg holds:
  - state enum
  - BURST_INCR, RESP_OKAY/EXOKAY/SLVERR/DECERR constants
  - function size_from_strb
- One sub-module is natural: axi_beat_cnt (clear, inc, len compare, last flag), shared by the R and W paths.

Test Plan:
- Single read, addr 0x0001_0010, len 0, slave ARREADY after 2 cycles, RDATA 0xDEADBEEF, RLAST -> ARLEN = 0, one rd_valid with rd_last, done=1, err=0.
- 4-beat read, len 3, RVALID gaps of 0/2/1 cycles, data 0x11,0x22,0x33,0x44 -> four rd_valid pulses in order, rd_last on 0x44, done, err=0.
- 4-beat write, len 3, WREADY low 3 cycles on beat 2 -> WDATA is held through the stall; 4 wr_pop pulses; WLAST only on beat 4; BREADY; done, err=0.
- Write with BRESP=SLVERR, then a read with RRESP=DECERR on beat 1 -> err=1 on both done pulses; all beats still delivered.
- Read len 3 with RLAST asserted on beat 2 -> done after beat 2, err=1; next request accepted in the done cycle.
- rst asserted mid-read after beat 1 -> next cycle all VALID/READY low, state IDLE, req_ready=1, no done pulse.

Source files
------------

// File: rtl/axi_master_pkg.sv
// ============================================================================
// Module      : axi_master_pkg
// Description : Shared types and constants for the AXI4 burst master:
//               FSM state encoding, AXI burst/response codes and a helper
//               that converts a strobe width into an AXI SIZE field.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package axi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5
  } state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // AXI SIZE is log2 of the bytes per beat; strb_w must be a power of two.
  function automatic logic [2:0] size_from_strb(input int strb_w);
    logic [2:0] size;
    size = '0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == strb_w) size = i[2:0];
    end
    return size;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_beat_cnt.sv
// ============================================================================
// Module      : axi_beat_cnt
// Description : Burst beat counter shared by the read and write data paths.
//               Cleared when a request is accepted, advanced once per data
//               handshake, and saturates at len so a maximum-length burst
//               never wraps back to zero.
// Revision    : 1.0  initial release
// Ports       : clk, rst       clock, synchronous active-high reset
//               clear          restart the count at beat 0
//               inc            a beat was transferred this cycle
//               len            beats-1 of the current burst
//               last           current beat is the final one (count == len)
// ============================================================================
`default_nettype none

module axi_beat_cnt #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic [LEN_W-1:0] len,
  output logic             last
);

  localparam logic [LEN_W-1:0] C_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && !last) begin
      // Holding at len keeps the last flag asserted for any overrun beats.
      cnt_d = cnt_q + C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign last = (cnt_q == len);

endmodule

`default_nettype wire

// File: rtl/axi_burst_master.sv
// ============================================================================
// Module      : axi_burst_master
// Description : Single-outstanding AXI4 master bridge. Takes one INCR burst
//               request (1..2^LEN_W beats) from the core side, runs the
//               address phase, streams read beats out or pulls write beats in,
//               and reports completion with a one-cycle done pulse and an
//               error flag.
// Revision    : 1.0  initial release
// Ports       : clk, rst               clock, synchronous active-high reset
//               req_*                  request handshake, direction, addr, len
//               wr_data/wr_strb/wr_pop write beat source, pop per beat
//               rd_data/rd_valid/rd_last  registered read beat stream
//               done/err               completion pulse and sticky error
//               ar*/r*/aw*/w*/b*       AXI4 master channels
// ============================================================================
`default_nettype none

module axi_burst_master
  import axi_master_pkg::*;
#(
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] ID_VAL = '0,
  parameter int              ADDR_W = 32,
  parameter int              DATA_W = 32,
  parameter int              LEN_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  // core-side request
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [LEN_W-1:0]    req_len,
  // core-side write beats
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  output logic                wr_pop,
  // core-side read beats
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                rd_last,
  // completion
  output logic                done,
  output logic                err,
  // AXI read address
  output logic [ID_W-1:0]     arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [LEN_W-1:0]    arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  // AXI read data
  input  logic [ID_W-1:0]     rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  // AXI write address
  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [LEN_W-1:0]    awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  // AXI write data
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  // AXI write response
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  state_e              state_q,    state_d;
  logic [ADDR_W-1:0]   addr_q,     addr_d;
  logic [LEN_W-1:0]    len_q,      len_d;
  logic                err_q,      err_d;
  logic                done_q,     done_d;
  logic [DATA_W-1:0]   rd_data_q,  rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_last_q,  rd_last_d;

  logic                w_cnt_clear;
  logic                w_cnt_inc;
  logic                w_cnt_last;
  logic                w_wr_hs;

  axi_beat_cnt #(
    .LEN_W (LEN_W)
  ) u_beat_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (w_cnt_clear),
    .inc   (w_cnt_inc),
    .len   (len_q),
    .last  (w_cnt_last)
  );

  assign w_wr_hs = (state_q == ST_W) && wready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    err_d       = err_q;
    done_d      = 1'b0;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    rd_last_d   = 1'b0;
    w_cnt_clear = 1'b0;
    w_cnt_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d      = req_addr;
          len_d       = req_len;
          err_d       = 1'b0;
          w_cnt_clear = 1'b1;
          state_d     = req_write ? ST_AW : ST_AR;
        end
      end
      ST_AR: begin
        if (arready) state_d = ST_R;
      end
      ST_R: begin
        if (rvalid) begin
          rd_data_d  = rdata;
          rd_valid_d = 1'b1;
          rd_last_d  = rlast;
          w_cnt_inc  = 1'b1;
          if ((rresp != RESP_OKAY) || (rid != ID_VAL)) err_d = 1'b1;
          if (rlast) begin
            // Short burst: RLAST arrived before the requested length.
            if (!w_cnt_last) err_d = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (w_cnt_last) begin
            // Overrun: beats beyond len are forwarded until RLAST.
            err_d = 1'b1;
          end
        end
      end
      ST_AW: begin
        if (awready) state_d = ST_W;
      end
      ST_W: begin
        if (w_wr_hs) begin
          w_cnt_inc = 1'b1;
          if (w_cnt_last) state_d = ST_B;
        end
      end
      ST_B: begin
        if (bvalid) begin
          if ((bresp != RESP_OKAY) || (bid != ID_VAL)) err_d = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      err_q      <= err_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);

  assign arid    = ID_VAL;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = size_from_strb(DATA_W / 8);
  assign arburst = BURST_INCR;
  assign arvalid = (state_q == ST_AR);
  assign rready  = (state_q == ST_R);

  assign awid    = ID_VAL;
  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = size_from_strb(DATA_W / 8);
  assign awburst = BURST_INCR;
  assign awvalid = (state_q == ST_AW);

  assign wvalid  = (state_q == ST_W);
  assign wdata   = wr_data;
  assign wstrb   = wr_strb;
  assign wlast   = (state_q == ST_W) && w_cnt_last;
  assign wr_pop  = w_wr_hs;

  assign bready  = (state_q == ST_B);

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

`default_nettype wire
